// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB first over WIDTH cycles.
// Results (S, Cout, V) are valid from the done strobe until the next accepted start.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             con,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             con_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic b_eff;
    logic sum;
    logic carry_nxt;
    logic last_bit;

    // Request protocol: start is a request taken only in IDLE (busy=0); while busy=1
    // it is ignored, and done pulses for one cycle when S/Cout/V become valid.
    always_comb begin
        b_eff     = b_sr[0] ^ con_r;
        sum       = a_sr[0] ^ b_eff ^ carry;
        carry_nxt = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
        last_bit  = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Carry starts at con so subtraction becomes A + ~B + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            con_r <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        con_r <= con;
                        carry <= con;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_nxt;
                    S     <= {sum, S[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        Cout <= carry_nxt;
                        V    <= carry ^ carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
